// File: rtl/alu_mem_seq_pkg.sv
// Shared types and constants for the load/operate/store sequencer.
// The control-bit indices follow the {zx,nx,zy,ny,f,no} ALU control word.
package alu_mem_seq_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 4;
  localparam int unsigned CtrlW = 6;

  localparam int unsigned CtrlZx = 5;
  localparam int unsigned CtrlNx = 4;
  localparam int unsigned CtrlZy = 3;
  localparam int unsigned CtrlNy = 2;
  localparam int unsigned CtrlF  = 1;
  localparam int unsigned CtrlNo = 0;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StExec = 3'd3,
    StWr   = 3'd4,
    StDone = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [AddrW-1:0] src_a;
    logic [AddrW-1:0] src_b;
    logic [AddrW-1:0] dst;
  } seq_addr_t;

endpackage

// File: rtl/alu_mem_seq.sv
// Bus master for a 16-word RAM and an external ALU: reads two operands,
// runs them through the ALU, writes the result back and reports it.
module alu_mem_seq
  import alu_mem_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AddrW-1:0] cmd_src_a,
  input  logic [AddrW-1:0] cmd_src_b,
  input  logic [AddrW-1:0] cmd_dst,
  input  logic [CtrlW-1:0] cmd_ctrl,
  output logic [AddrW-1:0] ram_addr,
  output logic [DataW-1:0] ram_din,
  output logic             ram_rw,
  input  logic [DataW-1:0] ram_dout,
  output logic [DataW-1:0] alu_x,
  output logic [DataW-1:0] alu_y,
  output logic [CtrlW-1:0] alu_ctrl,
  input  logic [DataW-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             done,
  output logic [DataW-1:0] result,
  output logic             res_zr,
  output logic             res_ng
);

  seq_state_e       state_q, state_d;
  seq_addr_t        addr_q;
  logic [DataW-1:0] alu_x_q, alu_y_q, result_q;
  logic [CtrlW-1:0] alu_ctrl_q;
  logic             res_zr_q, res_ng_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_ctrl_q <= '0;
      result_q   <= '0;
      res_zr_q   <= 1'b0;
      res_ng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && cmd_valid) begin
        addr_q     <= '{src_a: cmd_src_a, src_b: cmd_src_b, dst: cmd_dst};
        alu_ctrl_q <= cmd_ctrl;
      end
      // RAM read data lags its address by one cycle.
      if (state_q == StRdB) alu_x_q <= ram_dout;
      if (state_q == StExec) alu_y_q <= ram_dout;
      if (state_q == StWr) begin
        result_q <= alu_out;
        res_zr_q <= alu_zr;
        res_ng_q <= alu_ng;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    ram_rw    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = StRdA;
      end
      StRdA: begin
        ram_addr = addr_q.src_a;
        state_d  = StRdB;
      end
      StRdB: begin
        ram_addr = addr_q.src_b;
        state_d  = StExec;
      end
      StExec: state_d = StWr;
      StWr: begin
        ram_addr = addr_q.dst;
        ram_din  = alu_out;
        ram_rw   = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_ctrl = alu_ctrl_q;
  assign result   = result_q;
  assign res_zr   = res_zr_q;
  assign res_ng   = res_ng_q;

endmodule
